dcache_line_xfer: RTL

Cache-line transfer engine for the data cache. Sits directly downstream of the data-cache control FSM: consumes its `Load` (refill) and `writeback` commands and moves one cache line word-by-word between the cache data array and main memory over a req/ack bus. It reports `busy` while working and pulses `done` when the whole command sequence completes, which releases the FSM's stall.

---
 rtl/dcache_pkg.sv | 16 +
 rtl/line_word_ctr.sv | 37 +++
 rtl/dcache_line_xfer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache line transfer engine.
package dcache_pkg;

  typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} xfer_state_t;

  localparam int unsigned DEF_WORDS_PER_LINE = 4;
  localparam int unsigned DEF_OFF_W          = $clog2(DEF_WORDS_PER_LINE);

  // Clears the word and byte offset bits, leaving the line base address.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned off_w);
    logic [63:0] mask;
    mask = (64'd1 << (off_w + 2)) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/line_word_ctr.sv
// Loadable wrapping word-index counter; last flags the final word of a line phase.
module line_word_ctr
  import dcache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OFF_W-1:0] start_idx,
  input  logic             inc,
  output logic [OFF_W-1:0] idx,
  output logic             last
);

  logic [OFF_W-1:0] idx_q;
  logic [OFF_W-1:0] cnt_q;

  // cnt_q counts increments since the load, independent of the start index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      idx_q <= start_idx;
      cnt_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + OFF_W'(1);
      cnt_q <= cnt_q + OFF_W'(1);
    end
  end

  assign idx  = idx_q;
  assign last = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/dcache_line_xfer.sv
// Cache-line writeback/refill engine between the data array and a req/ack memory bus.
// Define DCACHE_XFER_CWF_EN for critical-word-first refill ordering.
module dcache_line_xfer
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Load,
  input  logic              writeback,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic [OFF_W-1:0]  cache_word_idx,
  output logic              cache_we,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

`ifdef DCACHE_XFER_CWF_EN
  localparam bit CwfEn = 1'b1;
`else
  localparam bit CwfEn = 1'b0;
`endif

  xfer_state_t       state_q, state_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] victim_q, victim_d;
  logic              pend_q, pend_d;

  logic              ctr_load, ctr_inc, ctr_last;
  logic [OFF_W-1:0]  ctr_start, idx;
  logic [ADDR_W-1:0] sel_line, word_addr;

  function automatic logic [OFF_W-1:0] fill_start(input logic [ADDR_W-1:0] a);
    return CwfEn ? a[OFF_W+1:2] : '0;
  endfunction

  line_word_ctr #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_ctr (
    .clk      (CLK),
    .rst      (RST),
    .load     (ctr_load),
    .start_idx(ctr_start),
    .inc      (ctr_inc),
    .idx      (idx),
    .last     (ctr_last)
  );

  assign sel_line  = (state_q == StWb) ? victim_q : fill_q;
  assign word_addr = ADDR_W'(line_base(64'(sel_line), OFF_W)) | (ADDR_W'(idx) << 2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      fill_q   <= '0;
      victim_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      victim_q <= victim_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    victim_d       = victim_q;
    pend_d         = pend_q;
    ctr_load       = 1'b0;
    ctr_inc        = 1'b0;
    ctr_start      = '0;
    cache_word_idx = '0;
    cache_we       = 1'b0;
    cache_wdata    = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    busy           = (state_q != StIdle);
    done           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Load || writeback) begin
          fill_d    = fill_addr;
          victim_d  = victim_addr;
          pend_d    = Load;
          ctr_load  = 1'b1;
          ctr_start = writeback ? '0 : fill_start(fill_addr);
          state_d   = writeback ? StWb : StFill;
        end
      end
      StWb: begin
        mem_req        = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = word_addr;
        mem_wdata      = cache_rdata;
        cache_word_idx = idx;
        if (mem_ack) begin
          ctr_inc = 1'b1;
          if (ctr_last) begin
            if (pend_q) begin
              // Reload directly into the fill phase so there is no idle gap.
              ctr_load  = 1'b1;
              ctr_start = fill_start(fill_q);
              state_d   = StFill;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StFill: begin
        mem_req        = 1'b1;
        mem_addr       = word_addr;
        cache_word_idx = idx;
        if (mem_ack) begin
          cache_we    = 1'b1;
          cache_wdata = mem_rdata;
          ctr_inc     = 1'b1;
          if (ctr_last) state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        pend_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
